// File: rtl/fsm_pkg.sv
// rtl/fsm_pkg.sv - state encodings shared by the run/done controller and worker FSMs
package fsm_pkg;

    localparam int STATE_W = 2;

    // 2'b11 is deliberately unencoded; every FSM using this type recovers to S_IDLE from it.
    typedef enum logic [STATE_W-1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/fsm_run_counter.sv
// rtl/fsm_run_counter.sv - job cycle counter with terminal-count flag for the run worker
module fsm_run_counter #(
    parameter int CNT_WIDTH = 7
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clr,
    input  logic                 en,
    input  logic [CNT_WIDTH-1:0] num,
    output logic [CNT_WIDTH-1:0] cnt,
    output logic                 is_last
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Terminal compare fires before the counter could ever reach 2^CNT_WIDTH-1 and wrap.
    assign is_last = (cnt == (num - 1'b1));

endmodule

// File: rtl/fsm_run_worker.sv
// rtl/fsm_run_worker.sv - run/done handshake responder: counts N cycles per start pulse, then pulses done
module fsm_run_worker
    import fsm_pkg::*;
#(
    parameter int CNT_WIDTH = 7
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_run,
    input  logic [CNT_WIDTH-1:0] i_num_cnt,
    output logic                 o_idle,
    output logic                 o_running,
    output logic                 o_done,
    output logic [CNT_WIDTH-1:0] o_cnt
);

    state_t                 c_state;
    state_t                 n_state;
    logic [CNT_WIDTH-1:0]   num_lat;
    logic                   load_num;
    logic                   cnt_clr;
    logic                   cnt_en;
    logic [CNT_WIDTH-1:0]   cnt;
    logic                   is_last;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            c_state <= S_IDLE;
        end else begin
            c_state <= n_state;
        end
    end

    // N is captured only on an accepted start, so later i_num_cnt changes are invisible to the job.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            num_lat <= '0;
        end else if (load_num) begin
            num_lat <= i_num_cnt;
        end
    end

    always_comb begin
        n_state  = c_state;
        load_num = 1'b0;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;
        case (c_state)
            S_IDLE: begin
                if (i_run) begin
                    if (i_num_cnt != '0) begin
                        load_num = 1'b1;
                        cnt_clr  = 1'b1;
                        n_state  = S_RUN;
                    end else begin
                        // Zero-length job still answers with done so the initiator never stalls.
                        n_state = S_DONE;
                    end
                end
            end
            S_RUN: begin
                cnt_en = 1'b1;
                if (is_last) begin
                    cnt_clr = 1'b1;
                    n_state = S_DONE;
                end
            end
            S_DONE: begin
                n_state = S_IDLE;
            end
            default: begin
                n_state = S_IDLE;
            end
        endcase
    end

    fsm_run_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .num     (num_lat),
        .cnt     (cnt),
        .is_last (is_last)
    );

    assign o_idle    = (c_state == S_IDLE);
    assign o_running = (c_state == S_RUN);
    assign o_done    = (c_state == S_DONE);
    assign o_cnt     = o_running ? cnt : '0;

endmodule
